alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_seq_muldiv.sv | 73 +++++++
 rtl/alu_seq.sv | 116 +++++++++++
 tb/tb_alu_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode enum, FSM state encoding and default width shared by alu_seq and its iterative datapath.
package alu_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_NOR,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_DIVU, OP_REMU
  } op_e;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: one-bit-per-cycle shift-add multiplier and restoring divider.
// done marks the edge that completes the WIDTH-th step; res is the value that step produces.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH);
  logic run_q, run_d, div_q, div_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, diff;
  logic [WIDTH:0] r;
  logic ge;
  assign done = run_q && cnt_q == CW'(WIDTH - 1);
  assign res = (div_q && !rem_q) ? lo_d : hi_d;
  // hi is the accumulator (MUL) or partial remainder (DIV); lo is the multiplier or dividend/quotient
  always_comb begin
    r = {hi_q, lo_q[WIDTH-1]};
    ge = r >= {1'b0, b_q};
    diff = WIDTH'(r - {1'b0, b_q});
    run_d = run_q;
    div_d = div_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    b_d = b_q;
    if (start) begin
      run_d = 1'b1;
      div_d = DIV_EN && (op == OP_DIVU || op == OP_REMU);
      rem_d = DIV_EN && op == OP_REMU;
      cnt_d = '0;
      hi_d = '0;
      lo_d = a;
      b_d = b;
    end else if (run_q) begin
      run_d = !done;
      cnt_d = done ? '0 : cnt_q + CW'(1);
      hi_d = div_q ? (ge ? diff : r[WIDTH-1:0]) : (lo_q[0] ? hi_q + b_q : hi_q);
      lo_d = div_q ? {lo_q[WIDTH-2:0], ge} : lo_q >> 1;
      b_d = div_q ? b_q : b_q << 1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      rem_q <= 1'b0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      b_q <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q <= b_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU; single-cycle ops finish at accept, MUL/DIVU/REMU iterate WIDTH cycles.
// Define ALU_SEQ_DIV_EN to build DIVU/REMU; otherwise opcodes 12-13 report err like illegal ones.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [OPW-1:0]   ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ovf,
  output logic             err
);
`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int SW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, alu_r, md_res, sum, dif;
  logic zero_q, zero_d, ovf_q, ovf_d, err_q, err_d, alu_ovf;
  logic [3:0] opc;
  op_e op;
  logic [SW-1:0] sh;
  logic is_div, illegal, long_op, accept, md_done;
  assign opc = 4'(ALUControl);
  assign op = op_e'(opc);
  assign sh = srcB[SW-1:0];
  assign is_div = op == OP_DIVU || op == OP_REMU;
  assign illegal = (|(ALUControl >> 4)) || opc > 4'd13 || (!DIV_EN && is_div);
  assign long_op = !illegal && (op == OP_MUL || is_div);
  assign in_ready = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign accept = in_valid && in_ready;
  assign res = res_q;
  assign zero = zero_q;
  assign ovf = ovf_q;
  assign err = err_q;
  alu_seq_muldiv #(.WIDTH(WIDTH), .DIV_EN(DIV_EN)) u_muldiv (
    .clk(clk), .rst_n(rst_n), .start(accept && long_op), .op(op),
    .a(srcA), .b(srcB), .done(md_done), .res(md_res)
  );
  always_comb begin
    sum = srcA + srcB;
    dif = srcA - srcB;
    alu_r = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r = sum;
        alu_ovf = srcA[WIDTH-1] == srcB[WIDTH-1] && sum[WIDTH-1] != srcA[WIDTH-1];
      end
      OP_SUB: begin
        alu_r = dif;
        alu_ovf = srcA[WIDTH-1] != srcB[WIDTH-1] && dif[WIDTH-1] != srcA[WIDTH-1];
      end
      OP_AND:  alu_r = srcA & srcB;
      OP_OR:   alu_r = srcA | srcB;
      OP_XOR:  alu_r = srcA ^ srcB;
      OP_SLT:  alu_r = WIDTH'($signed(srcA) < $signed(srcB));
      OP_SLTU: alu_r = WIDTH'(srcA < srcB);
      OP_NOR:  alu_r = ~(srcA | srcB);
      OP_SLL:  alu_r = srcA << sh;
      OP_SRL:  alu_r = srcA >> sh;
      OP_SRA:  alu_r = $signed(srcA) >>> sh;
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    res_d = res_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    err_d = err_q;
    if (accept) begin
      state_d = long_op ? S_BUSY : S_DONE;
      res_d = illegal ? '0 : alu_r;
      zero_d = illegal || alu_r == '0;
      ovf_d = !illegal && alu_ovf;
      err_d = illegal;
    end else if (state_q == S_BUSY && md_done) begin
      state_d = S_DONE;
      res_d = md_res;
      zero_d = md_res == '0;
      ovf_d = 1'b0;
      err_d = 1'b0;
    end else if (state_q == S_DONE && out_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q <= '0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random operations against a plain-arithmetic reference model.
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, zero, ovf, err;
  logic [31:0] srcA = '0, srcB = '0, res;
  logic [3:0] ALUControl = '0;
  int n_chk = 0, n_fail = 0;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output logic e, output int lat);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    r = '0; o = 1'b0; e = 1'b0; lat = 1; s = 0;
    case (op)
      4'd0: begin s = sa + sb; r = a + b; o = s > 64'sd2147483647 || s < -64'sd2147483648; end
      4'd1: begin s = sa - sb; r = a - b; o = s > 64'sd2147483647 || s < -64'sd2147483648; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = ~(a | b);
      4'd8: r = a << b[4:0];
      4'd9: r = a >> b[4:0];
      4'd10: r = 32'(sa >>> b[4:0]);
      4'd11: begin r = a * b; lat = 33; end
`ifdef ALU_SEQ_DIV_EN
      4'd12: begin r = (b == 0) ? 32'hFFFFFFFF : a / b; lat = 33; end
      4'd13: begin r = (b == 0) ? a : a % b; lat = 33; end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er, r0;
    logic eo, ee, rdy_seen;
    int el, lat;
    model(op, a, b, er, eo, ee, el);
    @(negedge clk);
    check($sformatf("op%0d in_ready before", op), in_ready, 1);
    srcA = a; srcB = b; ALUControl = op; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; srcA = $urandom; srcB = $urandom; ALUControl = 4'($urandom);
    lat = 0; rdy_seen = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (in_ready) rdy_seen = 1'b1;
      if (out_valid || lat >= 100) break;
    end
    check($sformatf("op%0d latency", op), lat, el);
    check($sformatf("op%0d in_ready low", op), rdy_seen, 0);
    check($sformatf("op%0d res a=%h b=%h", op, a, b), res, er);
    check($sformatf("op%0d zero", op), zero, er == 0);
    check($sformatf("op%0d ovf", op), ovf, eo);
    check($sformatf("op%0d err", op), err, ee);
    r0 = res;
    repeat (hold) begin
      in_valid = 1'b1; ALUControl = 4'($urandom); srcA = $urandom;
      @(negedge clk);
      check("hold res", res, r0);
      check("hold out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("consume out_valid", out_valid, 0);
    check("consume in_ready", in_ready, 1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7};
    return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
  endfunction

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset res", res, 0);
    check("reset zero", zero, 0);
    check("reset ovf/err", {ovf, err}, 0);
    rst_n = 1'b1;
    do_op(4'd0, 32'h7FFFFFFF, 32'h1, 0);
    check("add ovf literal", res, 32'h80000000);
    do_op(4'd1, 32'h80000000, 32'h1, 0);
    do_op(4'd5, 32'hFFFFFFFF, 32'h1, 0);
    do_op(4'd6, 32'hFFFFFFFF, 32'h1, 0);
    do_op(4'd10, 32'h80000000, 32'h4, 0);
    check("sra literal", res, 32'hF8000000);
    do_op(4'd8, 32'h1, 32'h21, 0);
    do_op(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    do_op(4'd7, 32'h0, 32'h0, 0);
    do_op(4'd11, 32'd12345, 32'd6789, 0);
    check("mul literal", res, 32'd83810205);
    do_op(4'd12, 32'd100, 32'd7, 0);
    do_op(4'd13, 32'd100, 32'd7, 0);
    do_op(4'd12, 32'd5, 32'd0, 0);
    do_op(4'd13, 32'd5, 32'd0, 0);
    do_op(4'd14, 32'h1234, 32'h5678, 0);
    do_op(4'd15, 32'h1, 32'h1, 0);
    do_op(4'd4, 32'hAAAA5555, 32'h5555AAAA, 5);
    // reset in the middle of a multiply must drop the result entirely
    @(negedge clk);
    srcA = 32'd3; srcB = 32'd5; ALUControl = 4'd11; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("mid reset out_valid", out_valid, 0);
    check("mid reset in_ready", in_ready, 1);
    check("mid reset res", res, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no result after reset", seen, 0);
    do_op(4'd11, 32'd7, 32'd9, 0);
    for (int i = 0; i < 50; i++)
      do_op(4'($urandom_range(0, 15)), pick(), ($urandom_range(0, 7) == 0) ? 32'd0 : pick(),
            int'($urandom_range(0, 2)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
